// File: rtl/cpu_err_pkg.sv
// Shared state encoding and default widths for the CPU error monitor.
// Optional last-source capture is enabled with CPU_ERR_LAST_SRC_EN.
package cpu_err_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR  = 2'd1,
        S_CLR  = 2'd2
    } state_t;

    localparam int DEF_NUM_SRC = 10;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TS_W    = 32;

endpackage

// File: rtl/err_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
// Shared by the first-capture and last-source logic of the error monitor.
module err_prio_enc #(
    parameter int NUM_SRC = 10,
    parameter int SRC_W   = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [SRC_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downwards so the lowest set index is written last.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = SRC_W'(i);
        end
    end

endmodule

// File: rtl/cpu_err_monitor.sv
// Sticky multi-source CPU error monitor with first-error capture and clear handshake.
// Define CPU_ERR_LAST_SRC_EN to register the most recent error source on last_src_o.
module cpu_err_monitor
    import cpu_err_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TS_W    = DEF_TS_W,
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] err_i,
    input  logic [NUM_SRC-1:0] err_mask_i,
    input  logic               clr_req_i,
    output logic               clr_ack_o,
    output logic               cpu_inner_error_o,
    output logic [NUM_SRC-1:0] err_status_o,
    output logic [SRC_W-1:0]   first_src_o,
    output logic [TS_W-1:0]    first_ts_o,
    output logic [CNT_W-1:0]   err_cnt_o,
    output logic [SRC_W-1:0]   last_src_o
);

    state_t               state;
    logic [TS_W-1:0]      ts;
    logic [NUM_SRC-1:0]   hit;
    logic                 any_hit;
    logic [SRC_W-1:0]     hit_idx;
    logic                 clear;
    logic [NUM_SRC-1:0]   status_base;
    logic [CNT_W-1:0]     cnt_base;
    logic                 held_base;

    assign hit   = err_i & err_mask_i;
    assign clear = clr_req_i && (state != S_CLR);

    err_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_prio (
        .req   (hit),
        .idx   (hit_idx),
        .valid (any_hit)
    );

    // Clear first, then merge this cycle's hits, so set wins on the clear edge.
    always_comb begin
        status_base = clear ? '0 : err_status_o;
        cnt_base    = clear ? '0 : err_cnt_o;
        held_base   = clear ? 1'b0 : cpu_inner_error_o;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            ts                <= '0;
            clr_ack_o         <= 1'b0;
            cpu_inner_error_o <= 1'b0;
            err_status_o      <= '0;
            first_src_o       <= '0;
            first_ts_o        <= '0;
            err_cnt_o         <= '0;
        end else begin
            ts <= ts + 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (clr_req_i)    state <= S_CLR;
                    else if (any_hit) state <= S_ERR;
                end
                S_ERR: begin
                    if (clr_req_i) state <= S_CLR;
                end
                S_CLR: begin
                    if (!clr_req_i)
                        state <= (cpu_inner_error_o || any_hit) ? S_ERR : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Every state moves to or stays in CLR exactly when a request is present.
            clr_ack_o         <= clr_req_i;
            err_status_o      <= status_base | hit;
            cpu_inner_error_o <= held_base | any_hit;
            if (any_hit && !(&cnt_base)) err_cnt_o <= cnt_base + 1'b1;
            else                         err_cnt_o <= cnt_base;
            if (any_hit && !held_base) begin
                first_src_o <= hit_idx;
                first_ts_o  <= ts;
            end else if (clear) begin
                first_src_o <= '0;
                first_ts_o  <= '0;
            end
        end
    end

`ifdef CPU_ERR_LAST_SRC_EN
    always_ff @(posedge clk) begin
        if (!rst_n)       last_src_o <= '0;
        else if (any_hit) last_src_o <= hit_idx;
        else if (clear)   last_src_o <= '0;
    end
`else
    assign last_src_o = '0;
`endif

endmodule
